// File: rtl/wbm_arbiter_if.sv
// Bus bundle between the DMA requesters, the arbiter and the bridge wbm_* port.
// Requester i owns bit i, slice [32i+31:32i] and [4i+3:4i] of the vectors.
interface wbm_arbiter_if #(
   parameter int N = 3
);
   logic [N-1:0]    req_cyc_i;
   logic [N-1:0]    req_stb_i;
   logic [N-1:0]    req_we_i;
   logic [N-1:0]    req_cab_i;
   logic [4*N-1:0]  req_sel_i;
   logic [32*N-1:0] req_adr_i;
   logic [32*N-1:0] req_dat_i;
   logic [32*N-1:0] req_dat64_i;
   logic [N-1:0]    req_ack_o;
   logic [N-1:0]    req_rty_o;
   logic [N-1:0]    req_err_o;
   logic [31:0]     req_dat_o;
   logic [31:0]     req_dat64_o;

   logic            wbm_cyc_o;
   logic            wbm_stb_o;
   logic            wbm_we_o;
   logic            wbm_cab_o;
   logic [3:0]      wbm_sel_o;
   logic [31:0]     wbm_adr_o;
   logic [31:0]     wbm_dat_o;
   logic [31:0]     wbm_dat64_o;
   logic            wbm_ack_i;
   logic            wbm_rty_i;
   logic            wbm_err_i;
   logic [31:0]     wbm_dat_i;
   logic [31:0]     wbm_dat64_i;

   modport master (
      input  req_cyc_i, req_stb_i, req_we_i, req_cab_i,
      input  req_sel_i, req_adr_i, req_dat_i, req_dat64_i,
      output req_ack_o, req_rty_o, req_err_o,
      output req_dat_o, req_dat64_o,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
      output wbm_sel_o, wbm_adr_o, wbm_dat_o, wbm_dat64_o,
      input  wbm_ack_i, wbm_rty_i, wbm_err_i,
      input  wbm_dat_i, wbm_dat64_i
   );

   modport slave (
      output req_cyc_i, req_stb_i, req_we_i, req_cab_i,
      output req_sel_i, req_adr_i, req_dat_i, req_dat64_i,
      input  req_ack_o, req_rty_o, req_err_o,
      input  req_dat_o, req_dat64_o,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
      input  wbm_sel_o, wbm_adr_o, wbm_dat_o, wbm_dat64_o,
      output wbm_ack_i, wbm_rty_i, wbm_err_i,
      output wbm_dat_i, wbm_dat64_i
   );
endinterface

// File: rtl/wbm_arbiter.sv
// Round-robin Wishbone arbiter sharing the bridge wbm_* port among N DMA
// requesters, with a stall watchdog that aborts unterminated transfers.
module wbm_arbiter #(
   parameter int N   = 3,
   parameter int TMO = 1023
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   wbm_arbiter_if.master bus,
   output logic [N-1:0] gnt_o,
   output logic         tmo_o
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, OWN, ABORT} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] own_q, own_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          tmo_q, tmo_d;

   logic [IW-1:0] pick, cand, own_nxt;
   logic          found;
   int            idx;

   logic          own_cyc, own_stb, term, stall;
   logic          o_cyc, o_stb, o_we, o_cab;
   logic [3:0]    o_sel;
   logic [31:0]   o_adr, o_dat, o_dat64;
   logic [N-1:0]  o_ack, o_rty, o_err, o_gnt;
   logic          o_tmo;

   assign own_cyc = bus.req_cyc_i[own_q];
   assign own_stb = bus.req_stb_i[own_q];
   assign term    = bus.wbm_ack_i | bus.wbm_rty_i | bus.wbm_err_i;
   assign stall   = (state_q == OWN) & own_stb & ~term;
   assign own_nxt = (own_q == IW'(N - 1)) ? '0 : own_q + IW'(1);

   // First pending requester at or above ptr, wrapping around.
   always_comb begin
      pick  = ptr_q;
      cand  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         cand = IW'(idx);
         if (!found && bus.req_cyc_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         own_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               own_d   = pick;
               cnt_d   = '0;
               state_d = OWN;
            end
         end
         OWN: begin
            if (!own_cyc) begin
               ptr_d   = own_nxt;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (stall) begin
               if (cnt_q == 16'(TMO - 1)) begin
                  cnt_d   = '0;
                  tmo_d   = 1'b1;
                  state_d = ABORT;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         ABORT: begin
            if (!own_cyc) begin
               ptr_d   = own_nxt;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Gating with reset drops the bus in the very cycle reset is sampled.
   always_comb begin
      o_cyc   = 1'b0;
      o_stb   = 1'b0;
      o_we    = 1'b0;
      o_cab   = 1'b0;
      o_sel   = '0;
      o_adr   = '0;
      o_dat   = '0;
      o_dat64 = '0;
      o_ack   = '0;
      o_rty   = '0;
      o_err   = '0;
      o_gnt   = '0;
      o_tmo   = 1'b0;
      if (!wb_rst_i && state_q != IDLE) begin
         o_gnt[own_q] = 1'b1;
         o_we    = bus.req_we_i[own_q];
         o_cab   = bus.req_cab_i[own_q];
         o_sel   = bus.req_sel_i[4*own_q +: 4];
         o_adr   = bus.req_adr_i[32*own_q +: 32];
         o_dat   = bus.req_dat_i[32*own_q +: 32];
         o_dat64 = bus.req_dat64_i[32*own_q +: 32];
         if (state_q == OWN) begin
            o_cyc        = own_cyc;
            o_stb        = own_stb;
            o_ack[own_q] = bus.wbm_ack_i;
            o_rty[own_q] = bus.wbm_rty_i;
            o_err[own_q] = bus.wbm_err_i;
         end else begin
            o_err[own_q] = tmo_q;
            o_tmo        = tmo_q;
         end
      end
   end

   assign bus.wbm_cyc_o   = o_cyc;
   assign bus.wbm_stb_o   = o_stb;
   assign bus.wbm_we_o    = o_we;
   assign bus.wbm_cab_o   = o_cab;
   assign bus.wbm_sel_o   = o_sel;
   assign bus.wbm_adr_o   = o_adr;
   assign bus.wbm_dat_o   = o_dat;
   assign bus.wbm_dat64_o = o_dat64;
   assign bus.req_ack_o   = o_ack;
   assign bus.req_rty_o   = o_rty;
   assign bus.req_err_o   = o_err;
   assign bus.req_dat_o   = bus.wbm_dat_i;
   assign bus.req_dat64_o = bus.wbm_dat64_i;
   assign gnt_o           = o_gnt;
   assign tmo_o           = o_tmo;
endmodule

// File: doc/wbm_arbiter.md
# wbm_arbiter

Round-robin Wishbone arbiter that shares the PCI bridge's single Wishbone slave port among N DMA requesters (descriptor fetch, read channel, write channel). It sits between the DMA engines and the `wbm_*` port group of the bridge wrapper, and holds each grant for a whole Wishbone cycle. A watchdog aborts any transfer the bridge never terminates and returns an error to the owning requester.

## Interface

Parameters:
- `N`, default 3: number of requesters. Requester index i occupies bit i, or slice [32i+31:32i] / [4i+3:4i].
- `TMO`, default 1023: stall cycles before abort. Range 2..65535; the counter is 16 bits.

Ports:
- `wb_clk_i`  in  1  clock; equal to the PCI clock.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `req_cyc_i`, `req_stb_i`, `req_we_i`, `req_cab_i`  in  N  per-requester Wishbone controls.
- `req_sel_i`  in  4N  byte selects.
- `req_adr_i`, `req_dat_i`, `req_dat64_i`  in  32N  address, low data, high data.
- `req_ack_o`, `req_rty_o`, `req_err_o`  out  N  per-requester terminations.
- `req_dat_o`, `req_dat64_o`  out  32  read data, broadcast to all requesters; valid only with that requester's ack.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `wbm_cab_o`  out  1  controls to the bridge.
- `wbm_sel_o`  out  4  byte selects to the bridge.
- `wbm_adr_o`, `wbm_dat_o`, `wbm_dat64_o`  out  32  address and write data to the bridge.
- `wbm_ack_i`, `wbm_rty_i`, `wbm_err_i`  in  1  terminations from the bridge.
- `wbm_dat_i`, `wbm_dat64_i`  in  32  read data from the bridge.
- `gnt_o`  out  N  one-hot current owner; 0 when idle.
- `tmo_o`  out  1  one-cycle pulse when an abort is issued.

## Operation

States: IDLE, OWN, ABORT.

IDLE
- All `wbm_*` outputs are 0.
- If any `req_cyc_i` is high, pick the first set bit searching upward, with wrap-around, from `ptr` (`ptr` = last owner + 1 mod N).
- Load `gnt` one-hot, clear `cnt`, go to OWN.

OWN
- Outputs to the bridge are combinational muxes of the owner's inputs: cyc, stb, we, cab, sel, adr, dat, dat64.
- Terminations from the bridge go only to the owner's `req_*_o` bit. Every other requester sees 0.
- `cnt` increments each cycle that `wbm_stb_o` is high and `wbm_ack_i`, `wbm_rty_i` and `wbm_err_i` are all low.
  - `cnt` clears on any termination or when stb is low.
  - If terminations arrive together, all are forwarded unchanged.
- Owner `req_cyc_i` low: go to IDLE and set `ptr` = owner+1 mod N. Burst (cab) tenures are never preempted.
- `cnt` == TMO-1 with a stall this cycle: go to ABORT.

ABORT
- `wbm_cyc_o` and `wbm_stb_o` are forced to 0.
- `req_err_o[owner]` = 1 on the first ABORT cycle only. `tmo_o` = 1 on that same cycle.
- Late bridge terminations are ignored.
- Stay in ABORT until owner `req_cyc_i` is low, then go to IDLE with `ptr` advanced.

Other rules:
- Reset mid-transfer: state returns to IDLE, `gnt` = 0, `ptr` = 0, `cnt` = 0. Bus outputs drop in the same cycle the reset is sampled.
- `gnt_o` equals `gnt` in OWN and ABORT, and is 0 in IDLE.

## Timing

- Reset values: `gnt_o`=0, `tmo_o`=0, all `wbm_*` outputs = 0, all `req_ack_o`/`req_rty_o`/`req_err_o` = 0. Data outputs are don't-care but must not be X; drive 0.
- Grant latency: `req_cyc_i` rising at edge k gives `wbm_cyc_o` high from edge k+1.
- Termination latency: zero-cycle combinational path from `wbm_ack_i`/`wbm_rty_i`/`wbm_err_i` to `req_*_o`. `req_dat_o` and `req_dat64_o` pass `wbm_dat_i` and `wbm_dat64_i` through directly.
- Every release passes through at least one IDLE cycle with `wbm_cyc_o` = 0.
- Back-to-back tenures by different requesters are therefore separated by exactly one cycle.
- A stall of exactly TMO cycles triggers the abort. The err pulse occurs on cycle TMO+1 after stb rose with no termination.
- Multiple requesters rising in the same cycle are resolved by `ptr` alone.

## Test plan

- Single requester 0 issues a 4-beat cab write with adr 0x1000 and data 0xA5A5_0000+i. Required: bridge sees identical beats starting one cycle after cyc, `req_ack_o[0]` mirrors `wbm_ack_i`, and `gnt_o` = 3'b001 then 0.
- Requesters 0, 1, 2 all raise cyc at the same edge after reset. Required: grant order 0, 1, 2, then 0 again; each tenure is separated by one idle cycle; no ack leaks to a non-owner.
- Requester 1 reads while the bridge returns rty and then ack with data 0xDEAD_BEEF. Required: rty goes only to `req_rty_o[1]`, the grant is kept while cyc stays high, and `req_dat_o` = 0xDEAD_BEEF with `req_ack_o[1]`.
- TMO=8, requester 2 asserts stb and the bridge never terminates. Required:
  - `req_err_o[2]` and `tmo_o` pulse high for one cycle, 9 cycles after stb.
  - `wbm_cyc_o` goes low that cycle.
  - A late `wbm_ack_i` is not forwarded.
  - IDLE follows once requester 2 drops cyc.
- Reset asserted mid-burst of requester 0. Required: all outputs 0 on the next edge, and after reset release requester 1 pending with requester 0 is granted first (`ptr` = 0).
